bram_read_arbiter: RTL and testbench

//  Shares the two read ports of a 2R/1W byte-write BRAM among N_REQ requesters using 2-grant round-robin.

---
 rtl/bram_arb_pkg.sv | 36 +++
 rtl/rr_2grant_picker.sv | 49 ++++
 rtl/bram_read_arbiter.sv | 128 ++++++++++++
 tb/tb_bram_read_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the 2R/1W BRAM read arbiter.
// Struct and type widths track the default arbiter geometry.
package bram_arb_pkg;

  localparam int N_REQ_DEF       = 4;
  localparam int INNER_WIDTH_DEF = 32;
  localparam int OUTER_WIDTH_DEF = 32;
  localparam int ARB_IDX_W       = $clog2(OUTER_WIDTH_DEF);
  localparam int ARB_ID_W        = $clog2(N_REQ_DEF);
  localparam int N_BYTES         = INNER_WIDTH_DEF / 8;

  typedef logic [ARB_IDX_W-1:0] idx_t;
  typedef logic [ARB_ID_W-1:0]  rid_t;

  typedef struct packed {
    logic                       valid;
    rid_t                       id;
    logic [N_BYTES-1:0]         byp_mask;
    logic [INNER_WIDTH_DEF-1:0] byp_data;
  } s1_port_t;

  // Bytes flagged in mask come from the same-cycle write, the rest from the BRAM.
  function automatic logic [INNER_WIDTH_DEF-1:0] byte_merge(
    input logic [N_BYTES-1:0]         mask,
    input logic [INNER_WIDTH_DEF-1:0] byp,
    input logic [INNER_WIDTH_DEF-1:0] rd
  );
    logic [INNER_WIDTH_DEF-1:0] res;
    res = rd;
    for (int b = 0; b < N_BYTES; b++) begin
      if (mask[b]) res[b*8 +: 8] = byp[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_2grant_picker.sv
// Combinational round-robin picker issuing up to two grants per cycle,
// scanning a doubled copy of the valid vector starting at ptr.
module rr_2grant_picker #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic             g0_valid,
  output logic [ID_W-1:0]  g0_id,
  output logic             g1_valid,
  output logic [ID_W-1:0]  g1_id,
  output logic [ID_W-1:0]  next_ptr
);

  logic [2*N_REQ-1:0] dbl;

  assign dbl = {valid, valid};

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  always_comb begin
    g0_valid = 1'b0;
    g0_id    = '0;
    g1_valid = 1'b0;
    g1_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (dbl[int'(ptr) + k]) begin
        if (!g0_valid) begin
          g0_valid = 1'b1;
          g0_id    = ID_W'((int'(ptr) + k) % N_REQ);
        end else if (!g1_valid) begin
          g1_valid = 1'b1;
          g1_id    = ID_W'((int'(ptr) + k) % N_REQ);
        end
      end
    end
  end

  // Resume the scan just past the most recent grant; hold when idle.
  always_comb begin
    if (g1_valid)      next_ptr = wrap_inc(g1_id);
    else if (g0_valid) next_ptr = wrap_inc(g0_id);
    else               next_ptr = ptr;
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Shares the two read ports of a 2R/1W byte-write BRAM among N_REQ requesters,
// routes 1-cycle read results back and merges same-cycle write bytes into them.
module bram_read_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEF,
  parameter  int INNER_WIDTH = INNER_WIDTH_DEF,
  parameter  int OUTER_WIDTH = OUTER_WIDTH_DEF,
  localparam int IDX_W       = $clog2(OUTER_WIDTH),
  localparam int ID_W        = $clog2(N_REQ),
  localparam int NB          = INNER_WIDTH / 8
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0][IDX_W-1:0]       req_index,
  output logic [N_REQ-1:0]                  req_ready,
  output logic [N_REQ-1:0]                  resp_valid,
  output logic [N_REQ-1:0][INNER_WIDTH-1:0] resp_data,
  input  logic [NB-1:0]                     wr_byte_en,
  input  logic [IDX_W-1:0]                  wr_index,
  input  logic [INNER_WIDTH-1:0]            wr_data,
  output logic                              port0_ren,
  output logic [IDX_W-1:0]                  port0_rindex,
  input  logic [INNER_WIDTH-1:0]            port0_rdata,
  output logic                              port1_ren,
  output logic [IDX_W-1:0]                  port1_rindex,
  input  logic [INNER_WIDTH-1:0]            port1_rdata,
  output logic [NB-1:0]                     wen_byte,
  output logic [IDX_W-1:0]                  windex,
  output logic [INNER_WIDTH-1:0]            wdata
);

  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        next_ptr;
  logic [ID_W-1:0]        g0_id;
  logic [ID_W-1:0]        g1_id;
  logic                   pk_g0_valid;
  logic                   pk_g1_valid;
  logic                   g0_valid;
  logic                   g1_valid;
  logic                   wr_active;
  s1_port_t               s1_0;
  s1_port_t               s1_1;
  s1_port_t               s1_0_d;
  s1_port_t               s1_1_d;
  logic [INNER_WIDTH-1:0] merged0;
  logic [INNER_WIDTH-1:0] merged1;

  rr_2grant_picker #(.N_REQ(N_REQ)) u_picker (
    .valid    (req_valid),
    .ptr      (rr_ptr),
    .g0_valid (pk_g0_valid),
    .g0_id    (g0_id),
    .g1_valid (pk_g1_valid),
    .g1_id    (g1_id),
    .next_ptr (next_ptr)
  );

  // No grant may leave the block while reset is held.
  assign g0_valid = pk_g0_valid & nRST;
  assign g1_valid = pk_g1_valid & nRST;

  always_comb begin
    req_ready = '0;
    if (g0_valid) req_ready[g0_id] = 1'b1;
    if (g1_valid) req_ready[g1_id] = 1'b1;
  end

  assign port0_ren    = g0_valid;
  assign port0_rindex = g0_valid ? req_index[g0_id] : '0;
  assign port1_ren    = g1_valid;
  assign port1_rindex = g1_valid ? req_index[g1_id] : '0;

  assign wen_byte = nRST ? wr_byte_en : '0;
  assign windex   = wr_index;
  assign wdata    = wr_data;

  assign wr_active = |wr_byte_en;

  // The BRAM returns pre-write data on a collision, so capture the write for the merge.
  always_comb begin
    s1_0_d       = '0;
    s1_0_d.valid = g0_valid;
    s1_0_d.id    = g0_id;
    if (g0_valid && wr_active && (wr_index == port0_rindex)) begin
      s1_0_d.byp_mask = wr_byte_en;
      s1_0_d.byp_data = wr_data;
    end
    s1_1_d       = '0;
    s1_1_d.valid = g1_valid;
    s1_1_d.id    = g1_id;
    if (g1_valid && wr_active && (wr_index == port1_rindex)) begin
      s1_1_d.byp_mask = wr_byte_en;
      s1_1_d.byp_data = wr_data;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr <= '0;
      s1_0   <= '0;
      s1_1   <= '0;
    end else begin
      rr_ptr <= next_ptr;
      s1_0   <= s1_0_d;
      s1_1   <= s1_1_d;
    end
  end

  assign merged0 = byte_merge(s1_0.byp_mask, s1_0.byp_data, port0_rdata);
  assign merged1 = byte_merge(s1_1.byp_mask, s1_1.byp_data, port1_rdata);

  // The two ports always carry distinct requester ids, so the demux never overlaps.
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (s1_0.valid) begin
      resp_valid[s1_0.id] = 1'b1;
      resp_data[s1_0.id]  = merged0;
    end
    if (s1_1.valid) begin
      resp_valid[s1_1.id] = 1'b1;
      resp_data[s1_1.id]  = merged1;
    end
  end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Self-checking bench for bram_read_arbiter: a behavioural BRAM plus a
// round-robin/memory reference model that predicts grants and read data.
module tb_bram_read_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int IW = 5;
  localparam int NB = 4;

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic [N-1:0]         req_valid;
  logic [N-1:0][IW-1:0] req_index;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         resp_valid;
  logic [N-1:0][W-1:0]  resp_data;
  logic [NB-1:0]        wr_byte_en;
  logic [IW-1:0]        wr_index;
  logic [W-1:0]         wr_data;
  logic                 port0_ren, port1_ren;
  logic [IW-1:0]        port0_rindex, port1_rindex;
  logic [W-1:0]         port0_rdata, port1_rdata;
  logic [NB-1:0]        wen_byte;
  logic [IW-1:0]        windex;
  logic [W-1:0]         wdata;

  bram_read_arbiter dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .req_valid    (req_valid),
    .req_index    (req_index),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .wr_byte_en   (wr_byte_en),
    .wr_index     (wr_index),
    .wr_data      (wr_data),
    .port0_ren    (port0_ren),
    .port0_rindex (port0_rindex),
    .port0_rdata  (port0_rdata),
    .port1_ren    (port1_ren),
    .port1_rindex (port1_rindex),
    .port1_rdata  (port1_rdata),
    .wen_byte     (wen_byte),
    .windex       (windex),
    .wdata        (wdata)
  );

  always #5 CLK = ~CLK;

  // Behavioural BRAM: registered reads return pre-write contents.
  logic [W-1:0] bram_mem [D];
  always @(posedge CLK) begin
    if (port0_ren) port0_rdata <= bram_mem[port0_rindex];
    if (port1_ren) port1_rdata <= bram_mem[port1_rindex];
    for (int b = 0; b < NB; b++)
      if (wen_byte[b]) bram_mem[windex][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  // Requester rule: an ungranted request keeps valid and index until granted.
  logic [N-1:0]         prev_wait = '0;
  logic [N-1:0][IW-1:0] prev_idx;
  always @(posedge CLK) begin
    for (int i = 0; i < N; i++)
      if (nRST && prev_wait[i])
        assert (req_valid[i] && req_index[i] == prev_idx[i])
          else $error("requester %0d dropped or changed a pending request", i);
    prev_wait <= nRST ? (req_valid & ~req_ready) : '0;
    prev_idx  <= req_index;
  end

  // Reference model state
  int           n_vec = 0;
  int           n_err = 0;
  int           m_ptr;
  logic [N-1:0] exp_v;
  logic [W-1:0] exp_d [N];
  logic [W-1:0] ref_mem [D];

  function automatic void model_pick(input logic [N-1:0] v, input int ptr,
                                     output int g0, output int g1);
    g0 = -1;
    g1 = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) begin
        if (g0 < 0)      g0 = i;
        else if (g1 < 0) g1 = i;
      end
    end
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g0, g1;
    logic [N-1:0] r;
    model_pick(req_valid, m_ptr, g0, g1);
    r = '0;
    if (g0 >= 0) r[g0] = 1'b1;
    if (g1 >= 0) r[g1] = 1'b1;
    return r;
  endfunction

  // Advance the model by one cycle: a read sees memory after the same-cycle write.
  task automatic model_commit();
    int g0, g1;
    model_pick(req_valid, m_ptr, g0, g1);
    for (int b = 0; b < NB; b++)
      if (wr_byte_en[b]) ref_mem[wr_index][b*8 +: 8] = wr_data[b*8 +: 8];
    exp_v = '0;
    if (g0 >= 0) begin exp_v[g0] = 1'b1; exp_d[g0] = ref_mem[req_index[g0]]; end
    if (g1 >= 0) begin exp_v[g1] = 1'b1; exp_d[g1] = ref_mem[req_index[g1]]; end
    if (g1 >= 0)      m_ptr = (g1 + 1) % N;
    else if (g0 >= 0) m_ptr = (g0 + 1) % N;
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    req_valid  = '0;
    req_index  = '0;
    wr_byte_en = '0;
    wr_index   = '0;
    wr_data    = '0;
  endtask

  task automatic test_reset();
    nRST       = 1'b0;
    req_valid  = '1;
    req_index  = {5'd1, 5'd2, 5'd3, 5'd4};
    wr_byte_en = 4'hF;
    wr_index   = 5'd9;
    wr_data    = 32'hDEADBEEF;
    #6;
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_vec++; if (port0_ren !== 1'b0 || port1_ren !== 1'b0) begin n_err++; $display("FAIL reset_ren: got %b%b want 00", port0_ren, port1_ren); end
    n_vec++; if (port0_rindex !== '0 || port1_rindex !== '0) begin n_err++; $display("FAIL reset_rindex: got %0d/%0d want 0/0", port0_rindex, port1_rindex); end
    n_vec++; if (resp_valid !== '0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
    n_vec++; if (resp_data !== '0) begin n_err++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    n_vec++; if (wen_byte !== '0) begin n_err++; $display("FAIL reset_wen_byte: got %b want 0000", wen_byte); end
    tick();
    nRST  = 1'b1;
    m_ptr = 0;
    exp_v = '0;
    drive_idle();
  endtask

  task automatic test_preload();
    for (int a = 0; a < D; a++) begin
      wr_byte_en = 4'hF;
      wr_index   = IW'(a);
      wr_data    = (a == 5) ? 32'hA5A5A5A5 : (a == 3) ? 32'h11223344 : $urandom;
      #1;
      n_vec++;
      if (wen_byte !== 4'hF || windex !== IW'(a) || wdata !== wr_data) begin
        n_err++;
        $display("FAIL preload_write a=%0d: got be=%b idx=%0d data=%h want be=1111 idx=%0d data=%h",
                 a, wen_byte, windex, wdata, a, wr_data);
      end
      model_commit();
      tick();
    end
    drive_idle();
  endtask

  task automatic test_all_valid();
    logic [N-1:0] want [5];
    want = '{4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0011};
    req_index = {5'd14, 5'd12, 5'd10, 5'd8};
    for (int c = 0; c <= 5; c++) begin
      req_valid = (c < 4) ? 4'b1111 : (c == 4) ? 4'b0011 : 4'b0000;
      #1;
      if (c < 5) begin
        n_vec++;
        if (req_ready !== want[c]) begin n_err++; $display("FAIL all_valid_grant c=%0d: got %b want %b", c, req_ready, want[c]); end
      end
      if (c > 0) begin
        n_vec++;
        if (resp_valid !== want[c-1]) begin n_err++; $display("FAIL all_valid_resp_valid c=%0d: got %b want %b", c, resp_valid, want[c-1]); end
        for (int i = 0; i < N; i++) begin
          n_vec++;
          if (resp_data[i] !== (exp_v[i] ? exp_d[i] : '0)) begin
            n_err++;
            $display("FAIL all_valid_resp_data c=%0d req=%0d: got %h want %h", c, i, resp_data[i], exp_v[i] ? exp_d[i] : '0);
          end
        end
      end
      model_commit();
      tick();
    end
    drive_idle();
  endtask

  task automatic test_single_read();
    req_valid    = 4'b0001;
    req_index[0] = 5'd5;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    n_vec++; if (port0_ren !== 1'b1 || port0_rindex !== 5'd5) begin n_err++; $display("FAIL single_port0: got ren=%b idx=%0d want ren=1 idx=5", port0_ren, port0_rindex); end
    n_vec++; if (port1_ren !== 1'b0) begin n_err++; $display("FAIL single_port1_ren: got %b want 0", port1_ren); end
    model_commit();
    tick();
    drive_idle();
    #1;
    n_vec++; if (resp_valid !== 4'b0001) begin n_err++; $display("FAIL single_resp_valid: got %b want 0001", resp_valid); end
    n_vec++; if (resp_data[0] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL single_resp_data: got %h want a5a5a5a5", resp_data[0]); end
    n_vec++; if (resp_data[3:1] !== '0) begin n_err++; $display("FAIL single_idle_data: got %h want 0", resp_data[3:1]); end
    model_commit();
    tick();
  endtask

  task automatic test_write_bypass();
    req_valid    = 4'b0001;
    req_index[0] = 5'd3;
    wr_byte_en   = 4'b0101;
    wr_index     = 5'd3;
    wr_data      = 32'hAABBCCDD;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bypass_ready: got %b want 0001", req_ready); end
    model_commit();
    tick();
    // A write in the response cycle must not leak into that response.
    drive_idle();
    wr_byte_en = 4'hF;
    wr_index   = 5'd3;
    wr_data    = 32'hFFFFFFFF;
    #1;
    n_vec++; if (resp_valid !== 4'b0001) begin n_err++; $display("FAIL bypass_resp_valid: got %b want 0001", resp_valid); end
    n_vec++; if (resp_data[0] !== 32'h11BB33DD) begin n_err++; $display("FAIL bypass_resp_data: got %h want 11bb33dd", resp_data[0]); end
    model_commit();
    tick();
    drive_idle();
  endtask

  task automatic test_same_index();
    logic [W-1:0] want;
    want = {8'h12, 8'h34, ref_mem[7][15:0]};
    req_valid    = 4'b0110;
    req_index[1] = 5'd7;
    req_index[2] = 5'd7;
    wr_byte_en   = 4'b1100;
    wr_index     = 5'd7;
    wr_data      = 32'h12345678;
    #1;
    n_vec++; if (req_ready !== 4'b0110) begin n_err++; $display("FAIL same_idx_ready: got %b want 0110", req_ready); end
    n_vec++; if (port0_rindex !== 5'd7 || port1_rindex !== 5'd7) begin n_err++; $display("FAIL same_idx_rindex: got %0d/%0d want 7/7", port0_rindex, port1_rindex); end
    model_commit();
    tick();
    drive_idle();
    #1;
    n_vec++; if (resp_valid !== 4'b0110) begin n_err++; $display("FAIL same_idx_resp_valid: got %b want 0110", resp_valid); end
    n_vec++; if (resp_data[1] !== want) begin n_err++; $display("FAIL same_idx_data1: got %h want %h", resp_data[1], want); end
    n_vec++; if (resp_data[2] !== want) begin n_err++; $display("FAIL same_idx_data2: got %h want %h", resp_data[2], want); end
    model_commit();
    tick();
  endtask

  task automatic test_reset_in_flight();
    req_valid = 4'b1111;
    req_index = {5'd20, 5'd21, 5'd22, 5'd23};
    #1;
    n_vec++; if (req_ready !== model_ready()) begin n_err++; $display("FAIL inflight_grant: got %b want %b", req_ready, model_ready()); end
    model_commit();
    @(posedge CLK);
    #1;
    nRST       = 1'b0;
    req_valid  = '0;
    wr_byte_en = 4'hF;
    wr_index   = 5'd9;
    wr_data    = 32'h0BADF00D;
    #1;
    n_vec++; if (resp_valid !== '0) begin n_err++; $display("FAIL inflight_resp_during_reset: got %b want 0000", resp_valid); end
    n_vec++; if (wen_byte !== '0) begin n_err++; $display("FAIL inflight_wen_gated: got %b want 0000", wen_byte); end
    m_ptr = 0;
    exp_v = '0;
    tick();
    req_valid = 4'b1111;
    #1;
    n_vec++; if (req_ready !== '0 || port0_ren !== 1'b0) begin n_err++; $display("FAIL inflight_ready_in_reset: got %b/%b want 0000/0", req_ready, port0_ren); end
    tick();
    nRST       = 1'b1;
    drive_idle();
    req_valid  = 4'b1001;
    req_index[0] = 5'd9;
    req_index[3] = 5'd12;
    #1;
    n_vec++; if (resp_valid !== '0) begin n_err++; $display("FAIL inflight_resp_after_reset: got %b want 0000", resp_valid); end
    n_vec++; if (req_ready !== 4'b1001) begin n_err++; $display("FAIL post_reset_ready: got %b want 1001", req_ready); end
    n_vec++; if (port0_rindex !== 5'd9 || port1_rindex !== 5'd12) begin n_err++; $display("FAIL post_reset_order: got %0d/%0d want 9/12", port0_rindex, port1_rindex); end
    model_commit();
    tick();
    drive_idle();
    #1;
    n_vec++; if (resp_valid !== 4'b1001) begin n_err++; $display("FAIL post_reset_resp_valid: got %b want 1001", resp_valid); end
    n_vec++; if (resp_data[0] !== exp_d[0] || resp_data[3] !== exp_d[3]) begin
      n_err++; $display("FAIL post_reset_resp_data: got %h/%h want %h/%h", resp_data[0], resp_data[3], exp_d[0], exp_d[3]);
    end
    model_commit();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] waiting;
    logic [N-1:0] rdy;
    int           wait_cnt [N];
    int           g0, g1;
    waiting = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!waiting[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_index[i] = IW'($urandom_range(0, 7));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        wr_byte_en = NB'($urandom);
        wr_index   = IW'($urandom_range(0, 7));
        wr_data    = $urandom;
      end else begin
        wr_byte_en = '0;
      end
      #1;
      n_vec++; if (resp_valid !== exp_v) begin n_err++; $display("FAIL rand_resp_valid cyc=%0d: got %b want %b", cyc, resp_valid, exp_v); end
      for (int i = 0; i < N; i++) begin
        n_vec++;
        if (resp_data[i] !== (exp_v[i] ? exp_d[i] : '0)) begin
          n_err++;
          $display("FAIL rand_resp_data cyc=%0d req=%0d: got %h want %h", cyc, i, resp_data[i], exp_v[i] ? exp_d[i] : '0);
        end
      end
      rdy = model_ready();
      model_pick(req_valid, m_ptr, g0, g1);
      n_vec++; if (req_ready !== rdy) begin n_err++; $display("FAIL rand_ready cyc=%0d: got %b want %b", cyc, req_ready, rdy); end
      n_vec++;
      if (port0_ren !== (g0 >= 0) || port0_rindex !== ((g0 >= 0) ? req_index[g0] : '0)) begin
        n_err++; $display("FAIL rand_port0 cyc=%0d: got ren=%b idx=%0d want ren=%b", cyc, port0_ren, port0_rindex, g0 >= 0);
      end
      n_vec++;
      if (port1_ren !== (g1 >= 0) || port1_rindex !== ((g1 >= 0) ? req_index[g1] : '0)) begin
        n_err++; $display("FAIL rand_port1 cyc=%0d: got ren=%b idx=%0d want ren=%b", cyc, port1_ren, port1_rindex, g1 >= 0);
      end
      n_vec++;
      if (wen_byte !== wr_byte_en || windex !== wr_index || wdata !== wr_data) begin
        n_err++; $display("FAIL rand_write_port cyc=%0d: got be=%b want be=%b", cyc, wen_byte, wr_byte_en);
      end
      for (int i = 0; i < N; i++) begin
        wait_cnt[i] = (req_valid[i] && !rdy[i]) ? wait_cnt[i] + 1 : 0;
        n_vec++;
        if (wait_cnt[i] > 1) begin n_err++; $display("FAIL rand_starve cyc=%0d req=%0d: waited %0d want <=1", cyc, i, wait_cnt[i]); end
      end
      waiting = req_valid & ~req_ready;
      model_commit();
      tick();
    end
    drive_idle();
    #1;
    n_vec++; if (resp_valid !== exp_v) begin n_err++; $display("FAIL rand_final_resp_valid: got %b want %b", resp_valid, exp_v); end
  endtask

  initial begin
    for (int a = 0; a < D; a++) ref_mem[a] = '0;
    for (int i = 0; i < N; i++) exp_d[i] = '0;
    test_reset();
    tick();
    test_preload();
    test_all_valid();
    test_single_read();
    test_write_bypass();
    test_same_index();
    test_reset_in_flight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the test sequence ended");
    $fatal(1);
  end

endmodule
